pkt_emitter: RTL and testbench

PKT_EMITTER -- requirements
Module: pkt_emitter

---
 rtl/pkt_emitter.sv | 185 ++++++++++++++++++
 tb/tb_pkt_emitter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_emitter.sv
// pkt_emitter: turns one metadata descriptor into a packet of 64-byte flits.
//
// A descriptor is accepted in IDLE, then the block emits a packet of
// ceil((hdr_len + len) / 64) flits (a zero total counts as one byte). Each
// byte carries a counting pattern seeded by an 8-bit per-packet sequence
// number. The descriptor is echoed unmodified on the metadata channel. Both
// output channels complete independently. The block returns to IDLE once the
// eop flit and the metadata have both been taken.
//
// Descriptor layout (metadata_t, packed): [31:16] hdr_len, [15:0] len.
//
// Handshakes: a transfer happens on a channel only in a cycle where its valid
// and ready are both high. A valid that is raised stays high, with its payload
// held stable, until the transfer.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_meta_data/valid/ready     descriptor input channel
//   out_pkt_data/valid/ready     packet flit output channel
//   out_pkt_sop/eop/empty        first/last flit markers, unused bytes in eop flit
//   out_meta_data/valid/ready    descriptor echo channel
//   stats_out_pkt/bytes          completed packet count and byte total
//   dbg_state                    current FSM state (0 = IDLE, 1 = BUSY)
module pkt_emitter #(
    parameter int DATA_W = 512,
    parameter int META_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [META_W-1:0] in_meta_data,
    input  logic              in_meta_valid,
    output logic              in_meta_ready,
    output logic [DATA_W-1:0] out_pkt_data,
    output logic              out_pkt_valid,
    input  logic              out_pkt_ready,
    output logic              out_pkt_sop,
    output logic              out_pkt_eop,
    output logic [5:0]        out_pkt_empty,
    output logic [META_W-1:0] out_meta_data,
    output logic              out_meta_valid,
    input  logic              out_meta_ready,
    output logic [31:0]       stats_out_pkt,
    output logic [63:0]       stats_out_bytes,
    output logic              dbg_state
);

    localparam int NB = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [META_W-1:0] meta_q, meta_d;
    logic [16:0]       total_q, total_d;
    logic [11:0]       rem_q, rem_d;       // flits left after the current one
    logic [5:0]        empty_q, empty_d;
    logic [7:0]        seq_q, seq_d;       // sequence number for the next packet
    logic [7:0]        base_q, base_d;     // byte 0 value of the current flit
    logic              sop_q, sop_d;
    logic              pkt_done_q, pkt_done_d;
    logic              meta_done_q, meta_done_d;
    logic [31:0]       st_pkt_q, st_pkt_d;
    logic [63:0]       st_bytes_q, st_bytes_d;

    logic [16:0] tot_raw, tot_eff;
    logic [17:0] tot_round;
    logic        pkt_fire, meta_fire, last_flit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            meta_q      <= '0;
            total_q     <= '0;
            rem_q       <= '0;
            empty_q     <= '0;
            seq_q       <= '0;
            base_q      <= '0;
            sop_q       <= 1'b0;
            pkt_done_q  <= 1'b0;
            meta_done_q <= 1'b0;
            st_pkt_q    <= '0;
            st_bytes_q  <= '0;
        end else begin
            state_q     <= state_d;
            meta_q      <= meta_d;
            total_q     <= total_d;
            rem_q       <= rem_d;
            empty_q     <= empty_d;
            seq_q       <= seq_d;
            base_q      <= base_d;
            sop_q       <= sop_d;
            pkt_done_q  <= pkt_done_d;
            meta_done_q <= meta_done_d;
            st_pkt_q    <= st_pkt_d;
            st_bytes_q  <= st_bytes_d;
        end
    end

    // Output decode. Payload fields are gated by valid so everything reads 0
    // while idle or in reset.
    always_comb begin
        // rst_n gating keeps ready low during reset and lets it rise in the
        // first cycle after release.
        in_meta_ready  = (state_q == IDLE) && rst_n;
        out_pkt_valid  = (state_q == BUSY) && !pkt_done_q;
        out_meta_valid = (state_q == BUSY) && !meta_done_q;
        last_flit      = (rem_q == 12'd0);
        out_pkt_sop    = out_pkt_valid && sop_q;
        out_pkt_eop    = out_pkt_valid && last_flit;
        out_pkt_empty  = out_pkt_eop ? empty_q : 6'd0;
        out_meta_data  = meta_q;
        out_pkt_data   = '0;
        if (out_pkt_valid) begin
            for (int i = 0; i < NB; i++) begin
                out_pkt_data[8*i +: 8] = base_q + 8'(i);
            end
        end
        stats_out_pkt   = st_pkt_q;
        stats_out_bytes = st_bytes_q;
        dbg_state       = state_q;
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        meta_d      = meta_q;
        total_d     = total_q;
        rem_d       = rem_q;
        empty_d     = empty_q;
        seq_d       = seq_q;
        base_d      = base_q;
        sop_d       = sop_q;
        pkt_done_d  = pkt_done_q;
        meta_done_d = meta_done_q;
        st_pkt_d    = st_pkt_q;
        st_bytes_d  = st_bytes_q;

        tot_raw   = {1'b0, in_meta_data[31:16]} + {1'b0, in_meta_data[15:0]};
        tot_eff   = (tot_raw == 17'd0) ? 17'd1 : tot_raw;
        tot_round = {1'b0, tot_eff} + 18'd63;   // upper 12 bits = flit count
        pkt_fire  = out_pkt_valid && out_pkt_ready;
        meta_fire = out_meta_valid && out_meta_ready;

        case (state_q)
            IDLE: begin
                if (in_meta_valid && in_meta_ready) begin
                    state_d     = BUSY;
                    meta_d      = in_meta_data;
                    total_d     = tot_eff;
                    rem_d       = tot_round[17:6] - 12'd1;
                    empty_d     = 6'd0 - tot_eff[5:0];
                    base_d      = seq_q;
                    seq_d       = seq_q + 8'd1;
                    sop_d       = 1'b1;
                    pkt_done_d  = 1'b0;
                    meta_done_d = 1'b0;
                end
            end
            BUSY: begin
                if (pkt_fire) begin
                    sop_d = 1'b0;
                    if (last_flit) begin
                        pkt_done_d = 1'b1;
                        st_pkt_d   = st_pkt_q + 32'd1;
                        st_bytes_d = st_bytes_q + {47'd0, total_q};
                    end else begin
                        rem_d  = rem_q - 12'd1;
                        base_d = base_q + 8'd64;
                    end
                end
                if (meta_fire) begin
                    meta_done_d = 1'b1;
                end
                if ((pkt_done_q || (pkt_fire && last_flit)) &&
                    (meta_done_q || meta_fire)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pkt_emitter.sv
// Testbench for pkt_emitter: scenario tasks drive descriptors, expected flits
// and metadata are queued at acceptance, and a negedge monitor pops and
// compares them on every transfer, also checking hold-while-stalled and
// ready/valid occupancy against the queue contents.
module tb_pkt_emitter;

    localparam int DATA_W = 512;
    localparam int META_W = 32;

    logic              clk;
    logic              rst_n;
    logic [META_W-1:0] in_meta_data;
    logic              in_meta_valid;
    logic              in_meta_ready;
    logic [DATA_W-1:0] out_pkt_data;
    logic              out_pkt_valid;
    logic              out_pkt_ready;
    logic              out_pkt_sop;
    logic              out_pkt_eop;
    logic [5:0]        out_pkt_empty;
    logic [META_W-1:0] out_meta_data;
    logic              out_meta_valid;
    logic              out_meta_ready;
    logic [31:0]       stats_out_pkt;
    logic [63:0]       stats_out_bytes;
    logic              dbg_state;

    pkt_emitter #(.DATA_W(DATA_W), .META_W(META_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_meta_data    (in_meta_data),
        .in_meta_valid   (in_meta_valid),
        .in_meta_ready   (in_meta_ready),
        .out_pkt_data    (out_pkt_data),
        .out_pkt_valid   (out_pkt_valid),
        .out_pkt_ready   (out_pkt_ready),
        .out_pkt_sop     (out_pkt_sop),
        .out_pkt_eop     (out_pkt_eop),
        .out_pkt_empty   (out_pkt_empty),
        .out_meta_data   (out_meta_data),
        .out_meta_valid  (out_meta_valid),
        .out_meta_ready  (out_meta_ready),
        .stats_out_pkt   (stats_out_pkt),
        .stats_out_bytes (stats_out_bytes),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic [5:0]        empty;
    } flit_t;

    flit_t             exp_q[$];
    logic [META_W-1:0] exp_meta_q[$];

    int          tests;
    int          fails;
    logic [7:0]  m_seq;
    logic [31:0] m_pkts;
    logic [63:0] m_bytes;
    bit          mon_en;
    bit          pkt_rand;
    int          meta_block;
    int          flits_seen;

    function automatic logic [DATA_W-1:0] gen_flit(input logic [7:0] s, input int k);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < 64; i++) begin
            d[8*i +: 8] = 8'((int'(s) + 64 * k + i) % 256);
        end
        return d;
    endfunction

    // ---------------- output-side ready driver ----------------
    always @(posedge clk) begin
        #1;
        out_pkt_ready = pkt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (meta_block > 0) begin
            out_meta_ready = 1'b0;
            meta_block     = meta_block - 1;
        end else begin
            out_meta_ready = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    flit_t             prev_f;
    logic [META_W-1:0] prev_m;
    bit                pstall;
    bit                mstall;

    always @(negedge clk) begin
        flit_t             cur;
        flit_t             e;
        logic [META_W-1:0] em;
        bit                busy_exp;
        if (mon_en) begin
            cur = {out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_empty};
            busy_exp = (exp_q.size() > 0) || (exp_meta_q.size() > 0);

            tests++;
            if (in_meta_ready !== !busy_exp) begin
                fails++;
                $display("FAIL in_meta_ready: got %0b, expected %0b", in_meta_ready, !busy_exp);
            end
            tests++;
            if (out_pkt_valid !== (exp_q.size() > 0)) begin
                fails++;
                $display("FAIL pkt_valid: got %0b, expected %0b", out_pkt_valid, exp_q.size() > 0);
            end
            tests++;
            if (out_meta_valid !== (exp_meta_q.size() > 0)) begin
                fails++;
                $display("FAIL meta_valid: got %0b, expected %0b", out_meta_valid, exp_meta_q.size() > 0);
            end
            if (pstall) begin
                tests++;
                if (out_pkt_valid !== 1'b1 || cur !== prev_f) begin
                    fails++;
                    $display("FAIL pkt_hold: valid=%0b sop=%0b eop=%0b empty=%0d, expected held sop=%0b eop=%0b empty=%0d",
                             out_pkt_valid, cur.sop, cur.eop, cur.empty, prev_f.sop, prev_f.eop, prev_f.empty);
                end
            end
            if (mstall) begin
                tests++;
                if (out_meta_valid !== 1'b1 || out_meta_data !== prev_m) begin
                    fails++;
                    $display("FAIL meta_hold: valid=%0b data=%h, expected held %h", out_meta_valid, out_meta_data, prev_m);
                end
            end
            if (out_pkt_valid && out_pkt_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                flits_seen++;
                tests++;
                if (cur !== e) begin
                    fails++;
                    $display("FAIL pkt_flit: got sop=%0b eop=%0b empty=%0d data=%h, expected sop=%0b eop=%0b empty=%0d data=%h",
                             cur.sop, cur.eop, cur.empty, cur.data, e.sop, e.eop, e.empty, e.data);
                end
            end
            if (out_meta_valid && out_meta_ready && exp_meta_q.size() > 0) begin
                em = exp_meta_q.pop_front();
                tests++;
                if (out_meta_data !== em) begin
                    fails++;
                    $display("FAIL meta_data: got %h, expected %h", out_meta_data, em);
                end
            end
            pstall = out_pkt_valid && !out_pkt_ready;
            mstall = out_meta_valid && !out_meta_ready;
            prev_f = cur;
            prev_m = out_meta_data;
        end else begin
            pstall = 1'b0;
            mstall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_desc(input logic [15:0] hdr, input logic [15:0] len);
        bit          acc;
        logic [16:0] tot;
        int          nf;
        logic [5:0]  emp;
        flit_t       f;
        @(posedge clk);
        #1;
        in_meta_data  = {hdr, len};
        in_meta_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 8000 && !acc; c++) begin
            @(negedge clk);
            if (in_meta_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        in_meta_valid = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL desc_accept: got no acceptance, expected in_meta_ready within 8000 cycles");
        end else begin
            tot = {1'b0, hdr} + {1'b0, len};
            if (tot == 17'd0) tot = 17'd1;
            nf  = (int'(tot) + 63) / 64;
            emp = 6'((64 - (int'(tot) % 64)) % 64);
            for (int k = 0; k < nf; k++) begin
                f.data  = gen_flit(m_seq, k);
                f.sop   = (k == 0);
                f.eop   = (k == nf - 1);
                f.empty = (k == nf - 1) ? emp : 6'd0;
                exp_q.push_back(f);
            end
            exp_meta_q.push_back({hdr, len});
            m_seq   = m_seq + 8'd1;
            m_pkts  = m_pkts + 32'd1;
            m_bytes = m_bytes + 64'(tot);
            @(negedge clk);
            tests++;
            if (!(out_pkt_valid && out_pkt_sop && out_meta_valid)) begin
                fails++;
                $display("FAIL first_flit_latency: got valid=%0b sop=%0b meta_valid=%0b, expected 1 1 1",
                         out_pkt_valid, out_pkt_sop, out_meta_valid);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() > 0 || exp_meta_q.size() > 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (exp_q.size() > 0 || exp_meta_q.size() > 0) begin
            fails++;
            $display("FAIL idle_timeout: got %0d flits and %0d metas pending, expected 0", exp_q.size(), exp_meta_q.size());
            exp_q.delete();
            exp_meta_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst_n         = 1'b0;
        in_meta_valid = 1'b0;
        exp_q.delete();
        exp_meta_q.delete();
        m_seq   = '0;
        m_pkts  = '0;
        m_bytes = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        tests++;
        if (out_pkt_valid !== 1'b0 || out_pkt_sop !== 1'b0 || out_pkt_eop !== 1'b0 ||
            out_pkt_empty !== 6'd0 || out_pkt_data !== '0 || out_meta_valid !== 1'b0 ||
            out_meta_data !== '0 || in_meta_ready !== 1'b0 || stats_out_pkt !== 32'd0 ||
            stats_out_bytes !== 64'd0 || dbg_state !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got pv=%0b mv=%0b rdy=%0b pkts=%0d bytes=%0d st=%0b, expected all 0",
                     out_pkt_valid, out_meta_valid, in_meta_ready, stats_out_pkt, stats_out_bytes, dbg_state);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_meta_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %0b, expected 1", in_meta_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_flit();
        send_desc(16'd14, 16'd50);
        wait_idle(100);
        tests++;
        if (stats_out_pkt !== 32'd1 || stats_out_bytes !== 64'd64) begin
            fails++;
            $display("FAIL single_flit_stats: got %0d pkts %0d bytes, expected 1 pkts 64 bytes", stats_out_pkt, stats_out_bytes);
        end
    endtask

    task automatic test_multi_flit();
        send_desc(16'd54, 16'd1000);
        wait_idle(200);
        tests++;
        if (stats_out_pkt !== 32'd2 || stats_out_bytes !== 64'd1118) begin
            fails++;
            $display("FAIL multi_flit_stats: got %0d pkts %0d bytes, expected 2 pkts 1118 bytes", stats_out_pkt, stats_out_bytes);
        end
    endtask

    task automatic test_stall();
        pkt_rand   = 1'b1;
        meta_block = 20;
        send_desc(16'd20, 16'd300);
        send_desc(16'd0, 16'd130);   // presented while busy: must be held off
        wait_idle(500);
        pkt_rand = 1'b0;
        tests++;
        if (stats_out_pkt !== m_pkts || stats_out_bytes !== m_bytes) begin
            fails++;
            $display("FAIL stall_stats: got %0d pkts %0d bytes, expected %0d pkts %0d bytes",
                     stats_out_pkt, stats_out_bytes, m_pkts, m_bytes);
        end
    endtask

    task automatic test_boundaries();
        send_desc(16'd0, 16'd0);
        send_desc(16'hffff, 16'hffff);
        wait_idle(5000);
        tests++;
        if (stats_out_pkt !== m_pkts || stats_out_bytes !== m_bytes) begin
            fails++;
            $display("FAIL boundary_stats: got %0d pkts %0d bytes, expected %0d pkts %0d bytes",
                     stats_out_pkt, stats_out_bytes, m_pkts, m_bytes);
        end
    endtask

    task automatic test_mid_reset();
        int start;
        int c;
        apply_reset();
        start = flits_seen;
        send_desc(16'd0, 16'd600);   // 10 flits
        c = 0;
        while (flits_seen < start + 3 && c < 100) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (flits_seen < start + 3) begin
            fails++;
            $display("FAIL mid_reset_progress: got %0d flits, expected 3", flits_seen - start);
        end
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        tests++;
        if (out_pkt_valid !== 1'b0 || out_pkt_sop !== 1'b0 || out_pkt_eop !== 1'b0 ||
            out_pkt_empty !== 6'd0 || out_pkt_data !== '0 || out_meta_valid !== 1'b0 ||
            out_meta_data !== '0 || in_meta_ready !== 1'b0 || stats_out_pkt !== 32'd0 ||
            stats_out_bytes !== 64'd0 || dbg_state !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got pv=%0b mv=%0b rdy=%0b pkts=%0d bytes=%0d st=%0b, expected all 0",
                     out_pkt_valid, out_meta_valid, in_meta_ready, stats_out_pkt, stats_out_bytes, dbg_state);
        end
        exp_q.delete();
        exp_meta_q.delete();
        m_seq   = '0;
        m_pkts  = '0;
        m_bytes = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_meta_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_mid_reset: got %0b, expected 1", in_meta_ready);
        end
        mon_en = 1'b1;
        send_desc(16'd4, 16'd6);
        wait_idle(100);
        tests++;
        if (stats_out_pkt !== 32'd1 || stats_out_bytes !== 64'd10) begin
            fails++;
            $display("FAIL mid_reset_stats: got %0d pkts %0d bytes, expected 1 pkts 10 bytes", stats_out_pkt, stats_out_bytes);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int p = 0; p < 300; p++) begin
            send_desc(16'($urandom_range(0, 32)), 16'($urandom_range(0, 32)));
        end
        wait_idle(200);
        tests++;
        if (stats_out_pkt !== 32'd300 || stats_out_bytes !== m_bytes) begin
            fails++;
            $display("FAIL b2b_stats: got %0d pkts %0d bytes, expected 300 pkts %0d bytes",
                     stats_out_pkt, stats_out_bytes, m_bytes);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        tests          = 0;
        fails          = 0;
        m_seq          = '0;
        m_pkts         = '0;
        m_bytes        = '0;
        mon_en         = 1'b0;
        pkt_rand       = 1'b0;
        meta_block     = 0;
        flits_seen     = 0;
        pstall         = 1'b0;
        mstall         = 1'b0;
        rst_n          = 1'b0;
        in_meta_valid  = 1'b0;
        in_meta_data   = '0;
        out_pkt_ready  = 1'b1;
        out_meta_ready = 1'b1;

        test_reset();
        test_single_flit();
        test_multi_flit();
        test_stall();
        test_boundaries();
        test_mid_reset();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 2000000 ns");
        $fatal(1, "timeout");
    end

endmodule
